wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port among the EXU, LSU and CSR writeback sources.

---
 rtl/wb_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: EXU/LSU/CSR writeback sources share one registered
// writeback stage; also reports operand pending/forward status to decode.
module wb_port_arbiter #(
  parameter int unsigned XLEN     = 64,
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rdr,
  input  logic [XLEN-1:0] exu_rd,

  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rdr,
  input  logic [XLEN-1:0] lsu_rd,

  input  logic            csr_valid,
  output logic            csr_ready,
  input  logic [4:0]      csr_rdr,
  input  logic [XLEN-1:0] csr_rd,

  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,

  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            rs1_pend,
  output logic            rs2_pend,
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] fwd_data,
  output logic            starve_err
);

  typedef enum logic [1:0] {SrcExu = 2'd0, SrcLsu = 2'd1, SrcCsr = 2'd2} src_e;

  src_e            rr_ptr;
  logic [2:0]      valid;
  logic [2:0]      req;
  logic [2:0]      grant;
  logic [2:0]      accept;
  logic [4:0]      rdr [3];
  logic [XLEN-1:0] rd [3];
  logic [3:0]      wait_q [3];
  logic [3:0]      wait_d [3];
  logic            starve_hit;
  logic            dup_rdr;

  assign valid  = {csr_valid, lsu_valid, exu_valid};
  assign rdr[0] = exu_rdr;
  assign rdr[1] = lsu_rdr;
  assign rdr[2] = csr_rdr;
  assign rd[0]  = exu_rd;
  assign rd[1]  = lsu_rd;
  assign rd[2]  = csr_rd;

  // Only requests that actually write a register compete for the port.
  always_comb begin
    req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      req[k] = valid[k] && (rdr[k] != 5'd0);
    end
  end

  always_comb begin
    grant = 3'b000;
    if (!RR_EN || rr_ptr == SrcExu) begin
      if (req[0])      grant = 3'b001;
      else if (req[1]) grant = 3'b010;
      else if (req[2]) grant = 3'b100;
    end else if (rr_ptr == SrcLsu) begin
      if (req[1])      grant = 3'b010;
      else if (req[2]) grant = 3'b100;
      else if (req[0]) grant = 3'b001;
    end else begin
      if (req[2])      grant = 3'b100;
      else if (req[0]) grant = 3'b001;
      else if (req[1]) grant = 3'b010;
    end
  end

  // x0 writes are swallowed immediately; they never need the port.
  always_comb begin
    accept = 3'b000;
    for (int k = 0; k < 3; k++) begin
      accept[k] = rst_n && valid[k] && ((rdr[k] == 5'd0) || grant[k]);
    end
  end

  assign exu_ready = accept[0];
  assign lsu_ready = accept[1];
  assign csr_ready = accept[2];

  always_comb begin
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (req[k] && !grant[k]) begin
        if (rdr[k] == q_rs1) rs1_pend = 1'b1;
        if (rdr[k] == q_rs2) rs2_pend = 1'b1;
      end
    end
  end

  assign rs1_fwd  = wb_en && (q_rs1 != 5'd0) && (wb_addr == q_rs1);
  assign rs2_fwd  = wb_en && (q_rs2 != 5'd0) && (wb_addr == q_rs2);
  assign fwd_data = wb_data;

  always_comb begin
    starve_hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (valid[k] && !accept[k]) begin
        wait_d[k] = (wait_q[k] == 4'hf) ? wait_q[k] : wait_q[k] + 4'd1;
      end else begin
        wait_d[k] = 4'd0;
      end
      if (32'(wait_d[k]) > WAIT_MAX) starve_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en      <= 1'b0;
      wb_addr    <= 5'd0;
      wb_data    <= '0;
      rr_ptr     <= SrcExu;
      starve_err <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        wait_q[k] <= 4'd0;
      end
    end else begin
      wb_en <= |grant;
      unique case (grant)
        3'b001: begin
          wb_addr <= rdr[0];
          wb_data <= rd[0];
          rr_ptr  <= SrcLsu;
        end
        3'b010: begin
          wb_addr <= rdr[1];
          wb_data <= rd[1];
          rr_ptr  <= SrcCsr;
        end
        3'b100: begin
          wb_addr <= rdr[2];
          wb_data <= rd[2];
          rr_ptr  <= SrcExu;
        end
        default: ;
      endcase
      for (int k = 0; k < 3; k++) begin
        wait_q[k] <= wait_d[k];
      end
      if (starve_hit) starve_err <= 1'b1;
    end
  end

  // Decode should have stalled the second writer; flag it, hardware still grants by priority.
  assign dup_rdr = (req[0] && req[1] && (rdr[0] == rdr[1])) ||
                   (req[0] && req[2] && (rdr[0] == rdr[2])) ||
                   (req[1] && req[2] && (rdr[1] == rdr[2]));

  assert property (@(posedge clk) disable iff (!rst_n) !dup_rdr);
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter: one round-robin and one fixed-priority instance,
// both checked every cycle against a transaction-level reference model.
module tb_wb_port_arbiter;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      exu_valid, exu_ready, lsu_valid, lsu_ready, csr_valid, csr_ready;
  logic [1:0]      wb_en, rs1_pend, rs2_pend, rs1_fwd, rs2_fwd, starve_err;
  logic [4:0]      exu_rdr [2], lsu_rdr [2], csr_rdr [2], wb_addr [2], q_rs1 [2], q_rs2 [2];
  logic [XLEN-1:0] exu_rd [2], lsu_rd [2], csr_rd [2], wb_data [2], fwd_data [2];

  wb_port_arbiter #(.XLEN(XLEN), .RR_EN(1'b1), .WAIT_MAX(15)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid[0]), .exu_ready(exu_ready[0]), .exu_rdr(exu_rdr[0]), .exu_rd(exu_rd[0]),
    .lsu_valid(lsu_valid[0]), .lsu_ready(lsu_ready[0]), .lsu_rdr(lsu_rdr[0]), .lsu_rd(lsu_rd[0]),
    .csr_valid(csr_valid[0]), .csr_ready(csr_ready[0]), .csr_rdr(csr_rdr[0]), .csr_rd(csr_rd[0]),
    .wb_en(wb_en[0]), .wb_addr(wb_addr[0]), .wb_data(wb_data[0]),
    .q_rs1(q_rs1[0]), .q_rs2(q_rs2[0]), .rs1_pend(rs1_pend[0]), .rs2_pend(rs2_pend[0]),
    .rs1_fwd(rs1_fwd[0]), .rs2_fwd(rs2_fwd[0]), .fwd_data(fwd_data[0]),
    .starve_err(starve_err[0])
  );

  wb_port_arbiter #(.XLEN(XLEN), .RR_EN(1'b0), .WAIT_MAX(3)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid[1]), .exu_ready(exu_ready[1]), .exu_rdr(exu_rdr[1]), .exu_rd(exu_rd[1]),
    .lsu_valid(lsu_valid[1]), .lsu_ready(lsu_ready[1]), .lsu_rdr(lsu_rdr[1]), .lsu_rd(lsu_rd[1]),
    .csr_valid(csr_valid[1]), .csr_ready(csr_ready[1]), .csr_rdr(csr_rdr[1]), .csr_rd(csr_rd[1]),
    .wb_en(wb_en[1]), .wb_addr(wb_addr[1]), .wb_data(wb_data[1]),
    .q_rs1(q_rs1[1]), .q_rs2(q_rs2[1]), .rs1_pend(rs1_pend[1]), .rs2_pend(rs2_pend[1]),
    .rs1_fwd(rs1_fwd[1]), .rs2_fwd(rs2_fwd[1]), .fwd_data(fwd_data[1]),
    .starve_err(starve_err[1])
  );

  // Source-side request state, index [instance][0=EXU,1=LSU,2=CSR].
  logic        s_valid [2][3];
  logic [4:0]  s_rdr [2][3];
  logic [63:0] s_data [2][3];
  logic [4:0]  s_q1 [2];
  logic [4:0]  s_q2 [2];

  // Reference model state.
  bit          m_wb_en [2];
  logic [4:0]  m_wb_addr [2];
  logic [63:0] m_wb_data [2];
  int          m_ptr [2];
  int          m_wait [2][3];
  bit          m_starve [2];
  int          m_rr [2]   = '{1, 0};
  int          m_wmax [2] = '{15, 3};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic got_ready(int i, int k);
    case (k)
      0:       return exu_ready[i];
      1:       return lsu_ready[i];
      default: return csr_ready[i];
    endcase
  endfunction

  function automatic bit exp_pend(int i, logic [4:0] q, int w);
    bit p = 1'b0;
    if (q == 5'd0) return 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (s_valid[i][k] && k != w && s_rdr[i][k] == q) p = 1'b1;
    end
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wb_en[i]   = 1'b0;
      m_wb_addr[i] = 5'd0;
      m_wb_data[i] = 64'd0;
      m_ptr[i]     = 0;
      m_starve[i]  = 1'b0;
      for (int k = 0; k < 3; k++) m_wait[i][k] = 0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      exu_valid[i] = s_valid[i][0];
      exu_rdr[i]   = s_rdr[i][0];
      exu_rd[i]    = s_data[i][0];
      lsu_valid[i] = s_valid[i][1];
      lsu_rdr[i]   = s_rdr[i][1];
      lsu_rd[i]    = s_data[i][1];
      csr_valid[i] = s_valid[i][2];
      csr_rdr[i]   = s_rdr[i][2];
      csr_rd[i]    = s_data[i][2];
      q_rs1[i]     = s_q1[i];
      q_rs2[i]     = s_q2[i];
    end
  endtask

  task automatic set_src(int i, int k, logic [4:0] r, logic [63:0] d);
    s_valid[i][k] = 1'b1;
    s_rdr[i][k]   = r;
    s_data[i][k]  = d;
  endtask

  // One clock cycle: drive, check everything against the model, advance model and sources.
  task automatic step();
    bit rdy [2][3];
    int win [2];
    apply();
    #1;
    for (int i = 0; i < 2; i++) begin
      win[i] = -1;
      if (rst_n) begin
        for (int n = 0; n < 3; n++) begin
          int k;
          k = (m_rr[i] != 0) ? (m_ptr[i] + n) % 3 : n;
          if (win[i] < 0 && s_valid[i][k] && s_rdr[i][k] != 5'd0) win[i] = k;
        end
      end
      for (int k = 0; k < 3; k++) begin
        rdy[i][k] = rst_n && s_valid[i][k] && (s_rdr[i][k] == 5'd0 || win[i] == k);
        check_eq($sformatf("i%0d_ready%0d", i, k), 64'(got_ready(i, k)), 64'(rdy[i][k]));
      end
      if (rst_n) begin
        check_eq($sformatf("i%0d_rs1_pend", i), 64'(rs1_pend[i]), 64'(exp_pend(i, s_q1[i], win[i])));
        check_eq($sformatf("i%0d_rs2_pend", i), 64'(rs2_pend[i]), 64'(exp_pend(i, s_q2[i], win[i])));
      end
      check_eq($sformatf("i%0d_rs1_fwd", i), 64'(rs1_fwd[i]),
               64'(m_wb_en[i] && s_q1[i] != 0 && m_wb_addr[i] == s_q1[i]));
      check_eq($sformatf("i%0d_rs2_fwd", i), 64'(rs2_fwd[i]),
               64'(m_wb_en[i] && s_q2[i] != 0 && m_wb_addr[i] == s_q2[i]));
      check_eq($sformatf("i%0d_fwd_data", i), fwd_data[i], m_wb_data[i]);
      check_eq($sformatf("i%0d_wb_en", i), 64'(wb_en[i]), 64'(m_wb_en[i]));
      check_eq($sformatf("i%0d_wb_addr", i), 64'(wb_addr[i]), 64'(m_wb_addr[i]));
      check_eq($sformatf("i%0d_wb_data", i), wb_data[i], m_wb_data[i]);
      check_eq($sformatf("i%0d_starve", i), 64'(starve_err[i]), 64'(m_starve[i]));
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_wb_en[i] = (win[i] >= 0);
        if (win[i] >= 0) begin
          m_wb_addr[i] = s_rdr[i][win[i]];
          m_wb_data[i] = s_data[i][win[i]];
          m_ptr[i]     = (win[i] + 1) % 3;
        end
        for (int k = 0; k < 3; k++) begin
          if (s_valid[i][k] && !rdy[i][k]) m_wait[i][k] = (m_wait[i][k] >= 15) ? 15 : m_wait[i][k] + 1;
          else m_wait[i][k] = 0;
          if (m_wait[i][k] > m_wmax[i]) m_starve[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++)
        if (rdy[i][k]) s_valid[i][k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic raise(int i, int k);
    logic [4:0] r;
    r = 5'($urandom_range(0, 12));
    for (int j = 0; j < 3; j++) begin
      if (j != k && s_valid[i][j] && s_rdr[i][j] == r) r = 5'd0;
    end
    set_src(i, k, r, {$urandom, $urandom});
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_q1[i] = 5'd0;
      s_q2[i] = 5'd0;
      for (int k = 0; k < 3; k++) begin
        s_valid[i][k] = 1'b0;
        s_rdr[i][k]   = 5'd0;
        s_data[i][k]  = 64'd0;
      end
    end
    rst_n = 1'b0;
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step();
    rst_n = 1'b1;

    // Single EXU write.
    set_src(0, 0, 5'd5, 64'h1234);
    step();
    check_eq("t1_wb_en", 64'(wb_en[0]), 64'd1);
    check_eq("t1_wb_addr", 64'(wb_addr[0]), 64'd5);
    check_eq("t1_wb_data", wb_data[0], 64'h1234);
    step();

    // All three right after reset: EXU, LSU, CSR in order.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_src(0, 0, 5'd1, 64'haa);
    set_src(0, 1, 5'd2, 64'hbb);
    set_src(0, 2, 5'd3, 64'hcc);
    for (int n = 1; n <= 3; n++) begin
      step();
      check_eq($sformatf("t2_wb_addr%0d", n), 64'(wb_addr[0]), 64'(n));
    end

    // Fixed priority: LSU starves behind a busy EXU.
    set_src(1, 1, 5'd6, 64'h66);
    for (int c = 0; c < 7; c++) begin
      set_src(1, 0, 5'd4, 64'(c));
      step();
      if (c == 4) check_eq("t3_starve_5th", 64'(starve_err[1]), 64'd1);
    end
    step();
    check_eq("t3_lsu_wb_addr", 64'(wb_addr[1]), 64'd6);
    step();
    check_eq("t3_starve_sticky", 64'(starve_err[1]), 64'd1);

    // x0 write and a real write accepted together.
    set_src(0, 1, 5'd0, 64'h99);
    set_src(0, 2, 5'd7, 64'h77);
    apply();
    #1;
    check_eq("t4_lsu_ready", 64'(lsu_ready[0]), 64'd1);
    check_eq("t4_csr_ready", 64'(csr_ready[0]), 64'd1);
    step();
    check_eq("t4_wb_en", 64'(wb_en[0]), 64'd1);
    check_eq("t4_wb_addr", 64'(wb_addr[0]), 64'd7);

    // Hazard: LSU waits on rd 9 behind EXU, then forwards.
    set_src(0, 0, 5'd3, 64'h33);
    set_src(0, 1, 5'd9, 64'hfeed_0009);
    s_q1[0] = 5'd9;
    s_q2[0] = 5'd0;
    apply();
    #1;
    check_eq("t5_rs1_pend", 64'(rs1_pend[0]), 64'd1);
    step();
    step();
    apply();
    #1;
    check_eq("t5_rs1_pend_after", 64'(rs1_pend[0]), 64'd0);
    check_eq("t5_rs1_fwd", 64'(rs1_fwd[0]), 64'd1);
    check_eq("t5_fwd_data", fwd_data[0], 64'hfeed_0009);
    check_eq("t5_rs2_pend", 64'(rs2_pend[0]), 64'd0);
    check_eq("t5_rs2_fwd", 64'(rs2_fwd[0]), 64'd0);

    // Reset while a write is in the wb stage.
    set_src(0, 0, 5'd11, 64'hb);
    step();
    check_eq("t6_wb_en_before", 64'(wb_en[0]), 64'd1);
    set_src(0, 1, 5'd12, 64'hc);
    rst_n = 1'b0;
    apply();
    #1;
    check_eq("t6_lsu_ready_rst", 64'(lsu_ready[0]), 64'd0);
    step();
    rst_n = 1'b1;
    check_eq("t6_wb_en", 64'(wb_en[0]), 64'd0);
    check_eq("t6_wb_addr", 64'(wb_addr[0]), 64'd0);
    check_eq("t6_starve", 64'(starve_err[1]), 64'd0);
    set_src(0, 2, 5'd13, 64'hd);
    set_src(0, 0, 5'd14, 64'he);
    step();
    check_eq("t6_ptr_exu", 64'(wb_addr[0]), 64'd14);

    // Random traffic with occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 3; k++) begin
          if (!s_valid[i][k] && $urandom_range(0, 1) == 1) raise(i, k);
        end
        s_q1[i] = 5'($urandom_range(0, 12));
        s_q2[i] = 5'($urandom_range(0, 12));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
